// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver with parity/framing checks and a valid/ready output
module uart_rx_core #(
    parameter int DATA_WIDTH  = 5,
    parameter int PARITY_TYPE = 2,
    parameter int STOP_BITS   = 2,
    parameter int BAUD_RATE   = 9600,
    parameter int CLK_FREQ    = 100_000_000
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx_core: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 8 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_rx_core: DATA_WIDTH must be 5..8 and STOP_BITS 1..2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    rx_meta, rx_s;
    logic [CNT_W-1:0]        cnt_q;
    logic                    tick;
    logic [IDX_W-1:0]        idx_q;
    logic                    stop_idx_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    perr_q, ferr_q;
    logic                    armed_q;
    logic                    par_exp;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // START waits half a bit so every later sample lands mid-bit
    assign tick    = (cnt_q == ((state_q == S_START) ? CNT_HALF : CNT_FULL));
    assign par_exp = (PARITY_TYPE == 1) ? ~^shift_q : ^shift_q;
    assign busy_o  = (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s && armed_q) state_d = S_START;
            end
            S_START: begin
                if (tick) state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && idx_q == IDX_LAST) state_d = (PARITY_TYPE != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (tick && stop_idx_q == STOP_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else if (tick || state_d != state_q || state_q == S_IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            shift_q    <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            case (state_q)
                S_START: begin
                    if (tick) begin
                        idx_q      <= '0;
                        stop_idx_q <= 1'b0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift_q[idx_q] <= rx_s;
                        idx_q          <= idx_q + IDX_W'(1);
                    end
                end
                S_PARITY: begin
                    if (tick) perr_q <= (rx_s != par_exp);
                end
                S_STOP: begin
                    if (tick) begin
                        if (!rx_s) ferr_q <= 1'b1;
                        stop_idx_q <= stop_idx_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
            // a break (line held low) must not look like a new start bit
            if (state_q == S_DONE && ferr_q) begin
                armed_q <= 1'b0;
            end else if (rx_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else if (state_q == S_DONE) begin
            data_o       <= shift_q;
            parity_err_o <= perr_q;
            frame_err_o  <= ferr_q;
            valid_o      <= 1'b1;
            if (valid_o && !ready_i) overrun_o <= 1'b1;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core in 5-bit even and 8-bit odd parity builds
module tb_uart_rx_core;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       rx5, rx8, ready5, ready8;
    logic [4:0] data5;
    logic [7:0] data8;
    logic       valid5, perr5, ferr5, ovr5, busy5;
    logic       valid8, perr8, ferr8, ovr8, busy8;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int words5 = 0;
    int words8 = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         t0;
        int         lat;
    } exp_t;

    exp_t q5[$];
    exp_t q8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_core #(
        .DATA_WIDTH(5), .PARITY_TYPE(2), .STOP_BITS(2),
        .BAUD_RATE(100_000), .CLK_FREQ(1_000_000)
    ) dut5 (
        .clk_i(clk), .arst_ni(arst_n), .rx_i(rx5), .data_o(data5), .valid_o(valid5),
        .ready_i(ready5), .parity_err_o(perr5), .frame_err_o(ferr5),
        .overrun_o(ovr5), .busy_o(busy5)
    );

    uart_rx_core #(
        .DATA_WIDTH(8), .PARITY_TYPE(1), .STOP_BITS(2),
        .BAUD_RATE(100_000), .CLK_FREQ(1_000_000)
    ) dut8 (
        .clk_i(clk), .arst_ni(arst_n), .rx_i(rx8), .data_o(data8), .valid_o(valid8),
        .ready_i(ready8), .parity_err_o(perr8), .frame_err_o(ferr8),
        .overrun_o(ovr8), .busy_o(busy8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_word(input string tag, input exp_t e, input logic [7:0] d,
                              input logic pe, input logic fe);
        check({tag, "_data"}, 32'(d), 32'(e.data));
        check({tag, "_parity_err"}, 32'(pe), 32'(e.perr));
        check({tag, "_frame_err"}, 32'(fe), 32'(e.ferr));
        check({tag, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
    endtask

    initial begin : mon5
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                seen = 1'b0;
            end else begin
                if (valid5 && !seen) begin
                    seen = 1'b1;
                    words5++;
                    check("dut5_word_expected", 32'(q5.size() > 0), 32'd1);
                    if (q5.size() > 0) begin
                        e = q5.pop_front();
                        check_word("dut5", e, {3'b000, data5}, perr5, ferr5);
                    end
                end
                if (!valid5 || ready5) seen = 1'b0;
            end
        end
    end

    initial begin : mon8
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                seen = 1'b0;
            end else begin
                if (valid8 && !seen) begin
                    seen = 1'b1;
                    words8++;
                    check("dut8_word_expected", 32'(q8.size() > 0), 32'd1);
                    if (q8.size() > 0) begin
                        e = q8.pop_front();
                        check_word("dut8", e, data8, perr8, ferr8);
                    end
                end
                if (!valid8 || ready8) seen = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic b);
        if (which == 0) rx5 = b;
        else rx8 = b;
        idle(CPB);
    endtask

    // one frame on the chosen line; expected word pushed at the start-bit edge
    task automatic send(input int which, input logic [7:0] d, input int dw, input int np,
                        input logic pbit, input int ns, input logic sval, input bit push,
                        input logic eperr, input logic eferr);
        exp_t e;
        e.data = d;
        e.perr = eperr;
        e.ferr = eferr;
        e.t0   = cyc;
        e.lat  = 2 + CPB / 2 + (dw + np + ns) * CPB + 2;
        if (push) begin
            if (which == 0) q5.push_back(e);
            else q8.push_back(e);
        end
        drive(which, 1'b0);
        for (int i = 0; i < dw; i++) drive(which, d[i]);
        if (np != 0) drive(which, pbit);
        for (int i = 0; i < ns; i++) drive(which, sval);
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        arst_n = 1'b0;
        rx5    = 1'b1;
        rx8    = 1'b1;
        ready5 = 1'b1;
        ready8 = 1'b1;
        idle(3);
        check("rst_data5", 32'(data5), 32'h0);
        check("rst_valid5", 32'(valid5), 32'h0);
        check("rst_perr5", 32'(perr5), 32'h0);
        check("rst_ferr5", 32'(ferr5), 32'h0);
        check("rst_overrun5", 32'(ovr5), 32'h0);
        check("rst_busy5", 32'(busy5), 32'h0);
        check("rst_valid8", 32'(valid8), 32'h0);
        check("rst_busy8", 32'(busy8), 32'h0);
        arst_n = 1'b1;
        idle(5);

        // even parity, clean frame
        send(0, 8'h15, 5, 1, 1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("even_frame_drained", 32'(q5.size()), 32'd0);

        // odd parity: wrong bit then right bit
        send(1, 8'hA5, 8, 1, 1'b0, 2, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(20);
        send(1, 8'hA5, 8, 1, 1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("odd_frames_drained", 32'(q8.size()), 32'd0);

        // false start glitch
        w = words5;
        rx5 = 1'b0;
        idle(3);
        rx5 = 1'b1;
        idle(2);
        check("false_start_busy_in_start", 32'(busy5), 32'd1);
        idle(30);
        check("false_start_busy_after", 32'(busy5), 32'd0);
        check("false_start_valid", 32'(valid5), 32'd0);
        check("false_start_words", 32'(words5 - w), 32'd0);

        // framing error followed by a held-low break
        w = words5;
        send(0, 8'h0F, 5, 1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(50);
        check("break_busy", 32'(busy5), 32'd0);
        check("break_words_low", 32'(words5 - w), 32'd1);
        rx5 = 1'b1;
        idle(30);
        check("break_words_high", 32'(words5 - w), 32'd1);
        check("break_drained", 32'(q5.size()), 32'd0);

        // back-to-back with the consumer ready
        send(0, 8'h11, 5, 1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        send(0, 8'h1E, 5, 1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("b2b_drained", 32'(q5.size()), 32'd0);
        check("b2b_overrun", 32'(ovr5), 32'd0);

        // back-to-back with the consumer stalled
        ready5 = 1'b0;
        send(0, 8'h11, 5, 1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        send(0, 8'h1E, 5, 1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        check("overrun_data", 32'(data5), 32'h1E);
        check("overrun_valid", 32'(valid5), 32'd1);
        check("overrun_flag", 32'(ovr5), 32'd1);
        check("overrun_perr", 32'(perr5), 32'd0);
        ready5 = 1'b1;
        idle(3);
        check("overrun_accepted", 32'(valid5), 32'd0);
        check("overrun_drained", 32'(q5.size()), 32'd0);

        // reset during data bit 2
        w = words5;
        drive(0, 1'b0);
        drive(0, 1'b1);
        drive(0, 1'b0);
        rx5 = 1'b0;
        idle(4);
        arst_n = 1'b0;
        idle(2);
        check("midrst_valid", 32'(valid5), 32'd0);
        check("midrst_busy", 32'(busy5), 32'd0);
        check("midrst_overrun", 32'(ovr5), 32'd0);
        check("midrst_data", 32'(data5), 32'h0);
        rx5 = 1'b1;
        arst_n = 1'b1;
        idle(30);
        check("midrst_busy_after", 32'(busy5), 32'd0);
        check("midrst_no_word", 32'(words5 - w), 32'd0);
        send(0, 8'h03, 5, 1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("midrst_clean_word", 32'(words5 - w), 32'd1);
        check("final_q5_empty", 32'(q5.size()), 32'd0);
        check("final_q8_empty", 32'(q8.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
